debug_streamer: RTL

- Parametrised successor to the top-level button-driven debug byte sequencer.
- Captures a data snapshot for any of NUM_TRIG trigger channels on a trigger rising edge and queues a request per channel.
- Serialises each request as an ASCII frame "DBG<ch>: <hex data>\r\n" onto a byte stream with ready/valid handshake, feeding the UART debug transmit path.
- Replaces fixed counter-timed sends with true back-pressure, multi-channel arbitration and drop accounting.

---
 rtl/fpga_template_pkg.sv | 28 ++
 rtl/dbg_trig_capture.sv | 83 ++++++++
 rtl/debug_streamer.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/fpga_template_pkg.sv
// Shared definitions for the debug streamer: ASCII frame constants, the
// streamer state encoding and the nibble-to-hex-digit helper.
package fpga_template_pkg;

   localparam int unsigned CH_W = 4;

   localparam logic [7:0] ASCII_D     = 8'h44;
   localparam logic [7:0] ASCII_B     = 8'h42;
   localparam logic [7:0] ASCII_G     = 8'h47;
   localparam logic [7:0] ASCII_COLON = 8'h3A;
   localparam logic [7:0] ASCII_SPACE = 8'h20;
   localparam logic [7:0] ASCII_CR    = 8'h0D;
   localparam logic [7:0] ASCII_LF    = 8'h0A;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_SEND = 2'd2,
      ST_GAP  = 2'd3
   } state_e;

   // Uppercase ASCII hex digit for a nibble.
   function automatic logic [7:0] nibble_to_ascii(input logic [3:0] n);
      if (n < 4'd10) return 8'h30 + {4'h0, n};
      else           return 8'h37 + {4'h0, n};
   endfunction

endpackage

// File: rtl/dbg_trig_capture.sv
// Trigger capture for the debug streamer.
// Detects rising edges on each trigger channel, latches a data snapshot and a
// pending flag per channel, and counts triggers lost to an already-pending
// channel (saturating).
// Ports:
//   clk, reset         clock, synchronous active-high reset
//   trig               per-channel trigger levels (synchronous to clk)
//   data_in            packed per-channel snapshot data
//   clr, clr_ch        clear strobe and channel from the streamer LOAD state
//   pending            per-channel request flags
//   snap               packed per-channel captured snapshots
//   drop_cnt           saturating dropped-trigger count
module dbg_trig_capture
   import fpga_template_pkg::*;
#(
   parameter int unsigned NUM_TRIG   = 2,
   parameter int unsigned DATA_BYTES = 4
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic [NUM_TRIG-1:0]              trig,
   input  logic [NUM_TRIG*DATA_BYTES*8-1:0] data_in,
   input  logic                             clr,
   input  logic [CH_W-1:0]                  clr_ch,
   output logic [NUM_TRIG-1:0]              pending,
   output logic [NUM_TRIG*DATA_BYTES*8-1:0] snap,
   output logic [7:0]                       drop_cnt
);

   localparam int unsigned SW = DATA_BYTES * 8;

   logic [NUM_TRIG-1:0]    trig_q, trig_d;
   logic [NUM_TRIG-1:0]    pending_q, pending_d;
   logic [NUM_TRIG*SW-1:0] snap_q, snap_d;
   logic [7:0]             drop_q, drop_d;
   logic [NUM_TRIG-1:0]    edge_c;
   logic [NUM_TRIG-1:0]    clr_hit_c;
   logic                   any_drop_c;

   // Edge detect, pending set/clear and drop accounting.
   always_comb begin
      trig_d     = trig;
      pending_d  = pending_q;
      snap_d     = snap_q;
      drop_d     = drop_q;
      any_drop_c = 1'b0;
      edge_c     = trig & ~trig_q;
      for (int i = 0; i < int'(NUM_TRIG); i++) begin
         clr_hit_c[i] = clr && (clr_ch == CH_W'(i));
         if (clr_hit_c[i]) pending_d[i] = 1'b0;
         // A new edge on the channel being cleared re-arms it instead of dropping.
         if (edge_c[i]) begin
            if (!pending_q[i] || clr_hit_c[i]) begin
               pending_d[i]         = 1'b1;
               snap_d[i*SW +: SW]   = data_in[i*SW +: SW];
            end else begin
               any_drop_c = 1'b1;
            end
         end
      end
      if (any_drop_c && (drop_q != 8'hFF)) drop_d = drop_q + 8'd1;
   end

   // Capture registers; trig_q resets high so a held trigger does not fire.
   always_ff @(posedge clk) begin
      if (reset) begin
         trig_q    <= '1;
         pending_q <= '0;
         snap_q    <= '0;
         drop_q    <= '0;
      end else begin
         trig_q    <= trig_d;
         pending_q <= pending_d;
         snap_q    <= snap_d;
         drop_q    <= drop_d;
      end
   end

   assign pending  = pending_q;
   assign snap     = snap_q;
   assign drop_cnt = drop_q;

endmodule

// File: rtl/debug_streamer.sv
// Multi-channel debug streamer.
// Serialises captured trigger snapshots as "DBG<ch>: <hex>\r\n" frames onto a
// ready/valid byte stream with round-robin channel arbitration and an optional
// idle gap after each accepted byte.
// Build option: DEBUG_STREAMER_RAW_EN sends the data bytes as raw binary.
// Ports:
//   clk, reset         clock, synchronous active-high reset
//   trig, data_in      trigger levels and packed snapshot data per channel
//   tx_data, tx_valid  byte stream to UART transmitter
//   tx_ready           transmitter accept
//   busy               state is not IDLE
//   active_ch          channel of the frame in flight
//   drop_cnt           saturating dropped-trigger count
module debug_streamer
   import fpga_template_pkg::*;
#(
   parameter int unsigned NUM_TRIG   = 2,
   parameter int unsigned DATA_BYTES = 4,
   parameter int unsigned GAP_CYCLES = 16
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic [NUM_TRIG-1:0]              trig,
   input  logic [NUM_TRIG*DATA_BYTES*8-1:0] data_in,
   output logic [7:0]                       tx_data,
   output logic                             tx_valid,
   input  logic                             tx_ready,
   output logic                             busy,
   output logic [3:0]                       active_ch,
   output logic [7:0]                       drop_cnt
);

   localparam int unsigned SW = DATA_BYTES * 8;
`ifdef DEBUG_STREAMER_RAW_EN
   localparam int unsigned PAY_LEN = DATA_BYTES;
`else
   localparam int unsigned PAY_LEN = 2 * DATA_BYTES;
`endif
   localparam int unsigned FRAME_LEN = 8 + PAY_LEN;
   localparam int unsigned IDX_W     = $clog2(FRAME_LEN + 1);
   localparam int unsigned GAP_W     = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

   state_e                 state_q, state_d;
   logic [IDX_W-1:0]       idx_q, idx_d;
   logic [GAP_W-1:0]       gap_q, gap_d;
   logic [SW-1:0]          frame_q, frame_d;
   logic [CH_W-1:0]        ch_q, ch_d;
   logic [CH_W-1:0]        sel_q, sel_d;
   logic [CH_W-1:0]        rr_q, rr_d;
   logic [7:0]             tx_data_q, tx_data_d;
   logic                   tx_valid_q, tx_valid_d;
   logic                   busy_q, busy_d;
   logic                   clr_c;
   logic [CH_W-1:0]        win_c;
   logic [NUM_TRIG-1:0]    pending_w;
   logic [NUM_TRIG*SW-1:0] snap_w;

   dbg_trig_capture #(
      .NUM_TRIG   (NUM_TRIG),
      .DATA_BYTES (DATA_BYTES)
   ) u_capture (
      .clk      (clk),
      .reset    (reset),
      .trig     (trig),
      .data_in  (data_in),
      .clr      (clr_c),
      .clr_ch   (sel_q),
      .pending  (pending_w),
      .snap     (snap_w),
      .drop_cnt (drop_cnt)
   );

   // Byte at position idx of the frame for channel ch carrying data.
   function automatic logic [7:0] frame_byte(input logic [IDX_W-1:0] idx,
                                             input logic [CH_W-1:0]  ch,
                                             input logic [SW-1:0]    data);
      int         p;
      int         k;
      logic [7:0] b;
      p = int'(idx) - 6;
      b = 8'h00;
      if      (idx == IDX_W'(0))           return ASCII_D;
      else if (idx == IDX_W'(1))           return ASCII_B;
      else if (idx == IDX_W'(2))           return ASCII_G;
      else if (idx == IDX_W'(3))           return nibble_to_ascii(ch);
      else if (idx == IDX_W'(4))           return ASCII_COLON;
      else if (idx == IDX_W'(5))           return ASCII_SPACE;
      else if (idx == IDX_W'(FRAME_LEN-2)) return ASCII_CR;
      else if (idx == IDX_W'(FRAME_LEN-1)) return ASCII_LF;
      else if (p >= 0 && p < int'(PAY_LEN)) begin
`ifdef DEBUG_STREAMER_RAW_EN
         k = p;
         b = data[(int'(DATA_BYTES) - 1 - k)*8 +: 8];
         return b;
`else
         k = p / 2;
         b = data[(int'(DATA_BYTES) - 1 - k)*8 +: 8];
         return (p % 2 == 0) ? nibble_to_ascii(b[7:4]) : nibble_to_ascii(b[3:0]);
`endif
      end
      return 8'h00;
   endfunction

   // Round-robin winner: first pending channel at or after rr_q.
   always_comb begin
      int c;
      win_c = '0;
      c     = 0;
      for (int off = int'(NUM_TRIG) - 1; off >= 0; off--) begin
         c = (int'(rr_q) + off) % int'(NUM_TRIG);
         if (pending_w[c]) win_c = CH_W'(c);
      end
   end

   // Next state and registered-output values.
   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      gap_d     = gap_q;
      frame_d   = frame_q;
      ch_d      = ch_q;
      sel_d     = sel_q;
      rr_d      = rr_q;
      clr_c     = 1'b0;
      tx_data_d = tx_data_q;

      case (state_q)
         ST_IDLE: begin
            if (|pending_w) begin
               sel_d   = win_c;
               state_d = ST_LOAD;
            end
         end
         ST_LOAD: begin
            frame_d = snap_w[int'(sel_q)*SW +: SW];
            ch_d    = sel_q;
            clr_c   = 1'b1;
            idx_d   = '0;
            rr_d    = (sel_q == CH_W'(NUM_TRIG-1)) ? '0 : sel_q + CH_W'(1);
            state_d = ST_SEND;
         end
         ST_SEND: begin
            if (tx_ready) begin
               idx_d = idx_q + IDX_W'(1);
               gap_d = '0;
               if (GAP_CYCLES == 0)
                  state_d = (idx_q == IDX_W'(FRAME_LEN-1)) ? ST_IDLE : ST_SEND;
               else
                  state_d = ST_GAP;
            end
         end
         ST_GAP: begin
            if (gap_q == GAP_W'(GAP_CYCLES-1))
               state_d = (idx_q == IDX_W'(FRAME_LEN)) ? ST_IDLE : ST_SEND;
            else
               gap_d = gap_q + GAP_W'(1);
         end
         default: state_d = ST_IDLE;
      endcase

      tx_valid_d = (state_d == ST_SEND);
      busy_d     = (state_d != ST_IDLE);
      // Index only moves on a handshake, so the byte holds under back-pressure.
      if (state_d == ST_SEND) tx_data_d = frame_byte(idx_d, ch_d, frame_d);
   end

   // State and output registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         idx_q      <= '0;
         gap_q      <= '0;
         frame_q    <= '0;
         ch_q       <= '0;
         sel_q      <= '0;
         rr_q       <= '0;
         tx_data_q  <= '0;
         tx_valid_q <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         gap_q      <= gap_d;
         frame_q    <= frame_d;
         ch_q       <= ch_d;
         sel_q      <= sel_d;
         rr_q       <= rr_d;
         tx_data_q  <= tx_data_d;
         tx_valid_q <= tx_valid_d;
         busy_q     <= busy_d;
      end
   end

   assign tx_data   = tx_data_q;
   assign tx_valid  = tx_valid_q;
   assign busy      = busy_q;
   assign active_ch = ch_q;

endmodule
